// File: rtl/avg_pool_2x2_stream_compute_if.sv
// Stream bundle for the 2x2 average-pool stage: pixel input channel and
// averaged-pixel output channel, each with valid/ready handshaking.
interface avg_pool_2x2_stream_compute_if #(
  parameter int DW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [63:0]   out_ctrl_vars;
  logic          frame_done;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl_vars, frame_done
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ctrl_vars, frame_done
  );
endinterface

// File: rtl/avg_pool_2x2_stream_compute.sv
// Streaming 2x2 average-pool stage: raster-order pixels in, one averaged pixel
// plus its {x_out, y_out, c, 0} loop-index vector out, with valid/ready backpressure.
module avg_pool_2x2_stream_compute #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int NUM_CH = 4,
  parameter int DW     = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  avg_pool_2x2_stream_compute_if.slave      bus
);

  localparam int          LB_DEPTH  = IMG_W / 2;
  localparam int          LB_AW     = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam logic [15:0] X_LAST    = 16'(IMG_W - 1);
  localparam logic [15:0] Y_LAST    = 16'(IMG_H - 1);
  localparam logic [15:0] C_LAST    = 16'(NUM_CH - 1);
  localparam logic [47:0] LAST_CTRL = {16'(IMG_W / 2 - 1), 16'(IMG_H / 2 - 1), 16'(NUM_CH - 1)};

  logic [15:0]   x_q, x_d;
  logic [15:0]   y_q, y_d;
  logic [15:0]   c_q, c_d;
  logic [DW:0]   pair_q, pair_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [63:0]   ctrl_q, ctrl_d;

  logic [DW:0]      line_mem [LB_DEPTH];
  logic [LB_AW-1:0] line_idx;
  logic [DW:0]      line_rd;
  logic [DW:0]      pair_sum;
  logic [DW+1:0]    total;
  logic             accept;
  logic             load;
  logic             line_we;

  assign bus.in_ready      = ~out_valid_q | bus.out_ready;
  assign accept            = bus.in_valid & bus.in_ready;
  assign line_idx          = x_q[LB_AW:1];
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_ctrl_vars = ctrl_q;
  assign bus.frame_done    = out_valid_q & bus.out_ready & ~flush & (ctrl_q[63:16] == LAST_CTRL);

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    c_d         = c_q;
    pair_d      = pair_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ctrl_d      = ctrl_q;
    pair_sum    = pair_q + {1'b0, bus.in_data};
    line_rd     = line_mem[line_idx];
    total       = {1'b0, line_rd} + {1'b0, pair_sum};
    line_we     = accept & x_q[0] & ~y_q[0] & ~flush;
    load        = accept & x_q[0] & y_q[0];

    if (accept) begin
      if (!x_q[0]) begin
        pair_d = {1'b0, bus.in_data};
      end
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d = '0;
          c_d = (c_q == C_LAST) ? '0 : c_q + 16'd1;
        end else begin
          y_d = y_q + 16'd1;
        end
      end else begin
        x_d = x_q + 16'd1;
      end
    end

    // A fresh load wins over retiring the current output in the same cycle
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = DW'(total >> 2);
      ctrl_d      = {1'b0, x_q[15:1], 1'b0, y_q[15:1], c_q, 16'd0};
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (flush) begin
      x_d         = '0;
      y_d         = '0;
      c_d         = '0;
      pair_d      = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      ctrl_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      y_q         <= '0;
      c_q         <= '0;
      pair_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ctrl_q      <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      c_q         <= c_d;
      pair_q      <= pair_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ctrl_q      <= ctrl_d;
    end
  end

  // Even rows park their pair sums here; odd rows read them back at the same column
  always_ff @(posedge clk) begin
    if (line_we) begin
      line_mem[line_idx] <= pair_sum;
    end
  end

endmodule
